// File: rtl/stack_mem_ctrl_if.sv
// Host-load and core memory bus between the stack-machine core/host and stack_mem_ctrl.
interface stack_mem_ctrl_if;
  logic       start;
  logic       clear;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_reset;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;

  // Controller side
  modport slave (
    input  start, clear, load_valid, load_data, cpu_addr, cpu_wdata,
    output load_ready, cpu_rdata, cpu_reset, result, result_valid, busy
  );

  // Host/core side
  modport master (
    output start, clear, load_valid, load_data, cpu_addr, cpu_wdata,
    input  load_ready, cpu_rdata, cpu_reset, result, result_valid, busy
  );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Program/data memory plus host-load controller for the stack-machine core:
// combinational reads, snooped two-cycle stores, and FIN-halt result capture.
module stack_mem_ctrl #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned HALT_CYC = 8
) (
  input logic             clock,
  input logic             reset_n,
  stack_mem_ctrl_if.slave bus
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam int unsigned DW = 8;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [1:0] SF_IDLE   = 2'd0;
  localparam logic [1:0] SF_ARM    = 2'd1;
  localparam logic [1:0] SF_COMMIT = 2'd2;

  localparam logic [DW-1:0] MARKER = 8'hFF;

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [1:0]    sf_q, sf_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    wd_q, wd_d;
  logic [DW-1:0] prev_wdata_q;
  logic          prev_run_q, prev_run_d;
  logic [DW-1:0] result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          busy_q, busy_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          load_ready_q, load_ready_d;

  logic          addr_mapped;
  logic          addr_zero;
  logic [IW-1:0] cpu_idx;
  logic [IW-1:0] ptr_idx;
  logic          load_we;
  logic          store_we;

  // Address decode for the core port
  always_comb begin
    addr_mapped = 32'(bus.cpu_addr) < DEPTH;
    addr_zero   = (bus.cpu_addr == 8'h00);
    cpu_idx     = bus.cpu_addr[IW-1:0];
    ptr_idx     = ptr_q[IW-1:0];
  end

  // Zero-latency read; unmapped addresses read as zero
  always_comb begin
    bus.cpu_rdata = 8'h00;
    if (addr_mapped) begin
      bus.cpu_rdata = mem[cpu_idx];
    end
  end

  // Top FSM, store snooper and halt watchdog next-state logic
  always_comb begin
    state_d    = state_q;
    sf_d       = sf_q;
    ptr_d      = ptr_q;
    wd_d       = wd_q;
    result_d   = result_q;
    load_we    = 1'b0;
    store_we   = 1'b0;

    if (bus.clear) begin
      state_d = ST_LOAD;
      ptr_d   = '0;
      sf_d    = SF_IDLE;
      wd_d    = 8'd0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          sf_d = SF_IDLE;
          wd_d = 8'd0;
          if (bus.load_valid && load_ready_q) begin
            load_we = 1'b1;
            ptr_d   = ptr_q + PW'(1);
          end
          if (bus.start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // Store sequence: marker cycle arms, next cycle passes, third commits
          case (sf_q)
            SF_IDLE: begin
              if ((bus.cpu_wdata == MARKER) && !addr_zero) begin
                sf_d = SF_ARM;
              end
            end
            SF_ARM: begin
              sf_d = SF_COMMIT;
            end
            SF_COMMIT: begin
              store_we = addr_mapped;
              sf_d     = SF_IDLE;
            end
            default: begin
              sf_d = SF_IDLE;
            end
          endcase
          // FIN keeps address 0 with a steady data value
          if (prev_run_q && addr_zero && (bus.cpu_wdata == prev_wdata_q)) begin
            wd_d = wd_q + 8'd1;
          end else begin
            wd_d = 8'd0;
          end
          if (wd_d == 8'(HALT_CYC)) begin
            result_d = bus.cpu_wdata;
            state_d  = ST_HALT;
            sf_d     = SF_IDLE;
            wd_d     = 8'd0;
          end
        end
        ST_HALT: begin
          sf_d = SF_IDLE;
          wd_d = 8'd0;
          if (bus.start) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_LOAD;
          sf_d    = SF_IDLE;
          wd_d    = 8'd0;
        end
      endcase
    end

    prev_run_d     = (state_q == ST_RUN) && (state_d == ST_RUN);
    cpu_reset_d    = (state_d != ST_RUN);
    busy_d         = (state_d == ST_RUN);
    result_valid_d = (state_d == ST_HALT);
    load_ready_d   = (state_d == ST_LOAD) && (32'(ptr_d) < DEPTH);
  end

  // Control and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_LOAD;
      sf_q           <= SF_IDLE;
      ptr_q          <= '0;
      wd_q           <= 8'd0;
      prev_wdata_q   <= 8'h00;
      prev_run_q     <= 1'b0;
      result_q       <= 8'h00;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      cpu_reset_q    <= 1'b1;
      load_ready_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      sf_q           <= sf_d;
      ptr_q          <= ptr_d;
      wd_q           <= wd_d;
      prev_wdata_q   <= bus.cpu_wdata;
      prev_run_q     <= prev_run_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      cpu_reset_q    <= cpu_reset_d;
      load_ready_q   <= load_ready_d;
    end
  end

  // Memory array is not reset; writes are suppressed while reset is held
  always_ff @(posedge clock) begin
    if (reset_n && load_we) begin
      mem[ptr_idx] <= bus.load_data;
    end else if (reset_n && store_we) begin
      mem[cpu_idx] <= bus.cpu_wdata;
    end
  end

  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.load_ready   = load_ready_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl; the core bus is driven by hand.
module tb_stack_mem_ctrl;

  localparam int unsigned HALT_CYC = 8;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] prog1 [4] = '{8'd13, 8'd5, 8'd26, 8'd0};
  logic [7:0] prog2 [5] = '{8'd13, 8'hFF, 8'd15, 8'd20, 8'd26};

  stack_mem_ctrl_if bus ();

  stack_mem_ctrl #(.DEPTH(32), .HALT_CYC(HALT_CYC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    bus.cpu_addr = addr;
    #1;
    check(tag, 32'(bus.cpu_rdata), 32'(exp));
  endtask

  task automatic drive(input logic [7:0] addr, input logic [7:0] wdata);
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic run_start();
    drive(8'd1, 8'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    clock          = 1'b0;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.clear      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.cpu_addr   = 8'h00;
    bus.cpu_wdata  = 8'h00;

    // Reset state
    #12;
    check("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'h00);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check("rst_load_ready", 32'(bus.load_ready), 32'd1);

    // Load PSI 5 / FIN, run, halt with result 5
    bus.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.load_data = prog1[i];
      step();
    end
    bus.load_valid = 1'b0;
    check("p1_ready_ptr4", 32'(bus.load_ready), 32'd1);
    rd("p1_mem0", 8'd0, 8'd13);
    rd("p1_mem1", 8'd1, 8'd5);
    rd("p1_mem2", 8'd2, 8'd26);
    rd("p1_mem3", 8'd3, 8'd0);
    step();
    run_start();
    check("p1_busy", 32'(bus.busy), 32'd1);
    check("p1_cpu_reset_low", 32'(bus.cpu_reset), 32'd0);
    step();
    step();
    drive(8'd0, 8'd5);
    for (int k = 0; k < int'(HALT_CYC); k++) step();
    check("p1_rv_early", 32'(bus.result_valid), 32'd0);
    step();
    check("p1_rv", 32'(bus.result_valid), 32'd1);
    check("p1_result", 32'(bus.result), 32'h05);
    check("p1_cpu_reset_halt", 32'(bus.cpu_reset), 32'd1);
    check("p1_busy_halt", 32'(bus.busy), 32'd0);

    // STR program: store 0xFF to address 20, no re-arm, no address-0 write
    pulse_clear();
    check("p2_clear_ready", 32'(bus.load_ready), 32'd1);
    check("p2_clear_rv", 32'(bus.result_valid), 32'd0);
    check("p2_result_kept", 32'(bus.result), 32'h05);
    bus.load_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.load_data = prog2[i];
      step();
    end
    bus.load_valid = 1'b0;
    run_start();
    drive(8'd20, 8'hFF); step();
    drive(8'd20, 8'hFF); step();
    drive(8'd20, 8'hFF); step();
    drive(8'd2, 8'h33);  step();
    drive(8'd2, 8'h44);  step();
    bus.cpu_wdata = 8'h00;
    rd("p2_mem20", 8'd20, 8'hFF);
    rd("p2_no_rearm_mem2", 8'd2, 8'd15);
    step();
    drive(8'd0, 8'hFF); step();
    drive(8'd0, 8'h55); step();
    drive(8'd0, 8'h66); step();
    rd("p2_mem0_no_write", 8'd0, 8'd13);
    drive(8'd0, 8'h00);
    for (int k = 0; k <= int'(HALT_CYC); k++) step();
    check("p2_rv", 32'(bus.result_valid), 32'd1);
    check("p2_result", 32'(bus.result), 32'h00);

    // Continuous load for 40 cycles saturates at 32 writes
    pulse_clear();
    bus.load_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.load_data = 8'(8'hA0 + i);
      step();
      if (i == 30) check("p3_ready_31", 32'(bus.load_ready), 32'd1);
      if (i == 31) check("p3_ready_32", 32'(bus.load_ready), 32'd0);
    end
    bus.load_valid = 1'b0;
    check("p3_ready_end", 32'(bus.load_ready), 32'd0);
    rd("p3_mem0", 8'd0, 8'hA0);
    rd("p3_mem20", 8'd20, 8'hB4);
    rd("p3_mem31", 8'd31, 8'hBF);
    rd("p3_unmapped", 8'h40, 8'h00);
    step();

    // Store committing to an unmapped address is dropped
    run_start();
    drive(8'd5, 8'hFF);  step();
    drive(8'd5, 8'h12);  step();
    drive(8'h40, 8'h99); step();
    bus.cpu_wdata = 8'h00;
    rd("p4_mem5", 8'd5, 8'hA5);
    rd("p4_mem0", 8'd0, 8'hA0);
    rd("p4_unmapped", 8'h40, 8'h00);
    step();

    // Clear during ARM aborts the store and returns to LOAD with ptr 0
    drive(8'd6, 8'hFF); step();
    drive(8'd6, 8'h21);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    drive(8'd6, 8'h22);
    check("p5_busy", 32'(bus.busy), 32'd0);
    check("p5_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    check("p5_ready", 32'(bus.load_ready), 32'd1);
    rd("p5_mem6", 8'd6, 8'hA6);
    step();
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h5A;
    step();
    bus.load_valid = 1'b0;
    rd("p5_ptr0_mem0", 8'd0, 8'h5A);
    rd("p5_mem1", 8'd1, 8'hA1);

    // Clear and start together in HALT: clear wins
    run_start();
    drive(8'd0, 8'h3C);
    for (int k = 0; k <= int'(HALT_CYC); k++) step();
    check("p5_rv", 32'(bus.result_valid), 32'd1);
    check("p5_result", 32'(bus.result), 32'h3C);
    bus.clear = 1'b1;
    bus.start = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check("p5_cs_busy", 32'(bus.busy), 32'd0);
    check("p5_cs_rv", 32'(bus.result_valid), 32'd0);
    check("p5_cs_ready", 32'(bus.load_ready), 32'd1);
    check("p5_cs_result", 32'(bus.result), 32'h3C);
    step();
    check("p5_cs_busy2", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-store in RUN
    run_start();
    check("p6_busy", 32'(bus.busy), 32'd1);
    drive(8'd7, 8'hFF); step();
    drive(8'd7, 8'h99);
    #2;
    reset_n = 1'b0;
    #1;
    check("p6_cpu_reset_async", 32'(bus.cpu_reset), 32'd1);
    check("p6_busy_async", 32'(bus.busy), 32'd0);
    check("p6_rv_async", 32'(bus.result_valid), 32'd0);
    #3;
    reset_n = 1'b1;
    step();
    step();
    check("p6_ready", 32'(bus.load_ready), 32'd1);
    rd("p6_mem7", 8'd7, 8'hA7);
    rd("p6_mem0", 8'd0, 8'h5A);
    rd("p6_mem6", 8'd6, 8'hA6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
